// File: rtl/uart_tx_scheduler_if.sv
// Byte-stream handshake between one text requester and the UART TX scheduler.
// The requester drives valid/data/last. The scheduler answers with ready.
interface uart_tx_scheduler_if;
    logic       valid;
    logic [7:0] data;
    logic       last;
    logic       ready;

    modport master (output valid, data, last, input ready);
    modport slave  (input valid, data, last, output ready);
endinterface

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between two byte-stream requesters. Grants are
// round-robin per message, and each byte is strobed out and then tracked through tx_busy.
module uart_tx_scheduler #(
    parameter int unsigned BUSY_TIMEOUT = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    uart_tx_scheduler_if.slave        req0,
    uart_tx_scheduler_if.slave        req1,
    output logic [7:0]                tx_data,
    output logic                      tx_stb,
    input  logic                      tx_busy,
    output logic [1:0]                grant,
    output logic                      timeout_err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_STROBE  = 3'd2;
    localparam logic [2:0] S_WAIT_HI = 3'd3;
    localparam logic [2:0] S_WAIT_LO = 3'd4;

    localparam logic [7:0] CNT_LIMIT = 8'(BUSY_TIMEOUT - 1);

    logic [2:0] state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic       rr_q, rr_d;
    logic [7:0] data_q, data_d;
    logic       last_q, last_d;
    logic [7:0] cnt_q, cnt_d;

    logic       sel_valid;
    logic [7:0] sel_data;
    logic       sel_last;
    logic       hit_limit;

    // Grant is one-hot, so the upper bit alone selects the owner's stream.
    assign sel_valid = grant_q[1] ? req1.valid : req0.valid;
    assign sel_data  = grant_q[1] ? req1.data  : req0.data;
    assign sel_last  = grant_q[1] ? req1.last  : req0.last;
    assign hit_limit = (cnt_q == CNT_LIMIT);

    assign req0.ready  = (state_q == S_LOAD) && grant_q[0] && req0.valid;
    assign req1.ready  = (state_q == S_LOAD) && grant_q[1] && req1.valid;
    assign tx_stb      = (state_q == S_STROBE);
    assign tx_data     = data_q;
    assign grant       = grant_q;
    assign timeout_err = (state_q == S_WAIT_HI) && !tx_busy && hit_limit;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        data_d  = data_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req0.valid || req1.valid) begin
                    // Requester 1 wins when it holds priority and is valid,
                    // or when requester 0 holds priority but is idle.
                    if (rr_q ? req1.valid : !req0.valid) grant_d = 2'b10;
                    else                                 grant_d = 2'b01;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (sel_valid) begin
                    data_d  = sel_data;
                    last_d  = sel_last;
                    state_d = S_STROBE;
                end
            end
            S_STROBE: begin
                cnt_d   = '0;
                state_d = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (tx_busy) begin
                    state_d = S_WAIT_LO;
                end else if (hit_limit) begin
                    state_d = S_WAIT_LO;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WAIT_LO: begin
                if (!tx_busy) begin
                    if (last_q) begin
                        grant_d = '0;
                        rr_d    = grant_q[0];
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            rr_q    <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            data_q  <= data_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
